// File: rtl/apb_req_master.sv
// APB3 initiator bridging a req/gnt/rvalid core bus onto SETUP/ACCESS transfers.
// One transfer in flight; ACCESS wait states are bounded by a timeout counter.
//
// state     | meaning
// ST_IDLE   | waiting for req_i; gnt_o follows req_i
// ST_SETUP  | PSEL=1, PENABLE=0 for one cycle
// ST_ACCESS | PSEL=1, PENABLE=1 until PREADY or timeout
// ST_RESP   | rvalid_o pulse with rdata_o/err_o
module apb_req_master #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                      clk_i,
  input  logic                      HRESETn,
  input  logic                      req_i,
  input  logic                      we_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic [31:0]               wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [31:0]               rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  // A zero-width counter is illegal, so the no-timeout build keeps one bit.
  localparam int              CNT_W   = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LIM = CNT_W'(TIMEOUT_CYCLES);
  localparam bit              TO_EN   = (TIMEOUT_CYCLES != 0);

  logic [1:0]       state_q;
  logic [1:0]       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_inc;
  logic             timeout_hit;

  // Saturating increment; the limit test uses the incremented value so the
  // abort happens on the TIMEOUT_CYCLES-th ACCESS cycle itself.
  assign cnt_inc     = (&cnt_q) ? cnt_q : cnt_q + CNT_ONE;
  assign timeout_hit = TO_EN && (cnt_inc == CNT_LIM);

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_i) state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: if (PREADY || timeout_hit) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign gnt_o    = HRESETn && (state_q == ST_IDLE) && req_i;
  assign PSEL     = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
  assign PENABLE  = (state_q == ST_ACCESS);
  assign rvalid_o = (state_q == ST_RESP);

  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      PADDR  <= '0;
      PWDATA <= '0;
      PWRITE <= 1'b0;
    end else if ((state_q == ST_IDLE) && req_i) begin
      PADDR  <= addr_i;
      PWRITE <= we_i;
      PWDATA <= we_i ? wdata_i : 32'h0;
    end
  end

  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      cnt_q <= '0;
    end else if (state_q == ST_SETUP) begin
      cnt_q <= '0;
    end else if ((state_q == ST_ACCESS) && !PREADY) begin
      cnt_q <= cnt_inc;
    end
  end

  // PREADY takes priority over a coincident timeout.
  always_ff @(posedge clk_i or negedge HRESETn) begin
    if (!HRESETn) begin
      rdata_o <= 32'h0;
      err_o   <= 1'b0;
    end else begin
      case (state_q)
        ST_ACCESS: begin
          if (PREADY) begin
            rdata_o <= PWRITE ? 32'h0 : PRDATA;
            err_o   <= PSLVERR;
          end else if (timeout_hit) begin
            rdata_o <= 32'h0;
            err_o   <= 1'b1;
          end
        end
        default: err_o <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_req_master.sv
// Bench for apb_req_master: directed scenarios plus random transfers checked
// against a cycle-budget model derived from wait-state count and timeout limit.
module tb_apb_req_master;
  localparam int AW = 12;
  localparam int TO = 4;

  logic          clk_i   = 1'b0;
  logic          HRESETn = 1'b0;
  logic          req_i   = 1'b0;
  logic          we_i    = 1'b0;
  logic [AW-1:0] addr_i  = '0;
  logic [31:0]   wdata_i = 32'h0;
  logic          gnt_o;
  logic          rvalid_o;
  logic [31:0]   rdata_o;
  logic          err_o;
  logic [AW-1:0] PADDR;
  logic [31:0]   PWDATA;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [31:0]   PRDATA  = 32'h0;
  logic          PREADY  = 1'b0;
  logic          PSLVERR = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0]   m_rdata  = 32'h0;
  logic [AW-1:0] m_paddr  = '0;
  logic          m_pwrite = 1'b0;
  logic [31:0]   m_pwdata = 32'h0;

  apb_req_master #(.APB_ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk_i), .HRESETn(HRESETn), .req_i(req_i), .we_i(we_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .gnt_o(gnt_o), .rvalid_o(rvalid_o),
    .rdata_o(rdata_o), .err_o(err_o), .PADDR(PADDR), .PWDATA(PWDATA),
    .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE), .PRDATA(PRDATA),
    .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with the DUT idle. The slave raises PREADY after
  // 'waits' wait states; more than TO-1 wait states means a timeout abort.
  task automatic xfer(input string name, input logic we, input logic [AW-1:0] addr,
                      input logic [31:0] wdata, input logic [31:0] prdata,
                      input int waits, input logic slverr);
    logic to;
    int   acc_n;
    int   last;
    int   resp;
    logic exp_err;
    to    = (waits >= TO);
    acc_n = to ? TO : waits + 1;
    last  = 1 + acc_n;
    resp  = last + 1;
    for (int k = 0; k <= resp; k++) begin
      if (k == 0) begin
        req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata;
      end else begin
        req_i = 1'($urandom_range(0, 1)); we_i = 1'($urandom_range(0, 1));
        addr_i = AW'($urandom); wdata_i = $urandom;
      end
      PREADY  = (!to && (k == 2 + waits));
      PRDATA  = PREADY ? prdata : $urandom;
      PSLVERR = PREADY ? slverr : 1'($urandom_range(0, 1));
      @(negedge clk_i);
      chk($sformatf("%s gnt k%0d", name, k), 32'(gnt_o), 32'(k == 0));
      chk($sformatf("%s paddr k%0d", name, k), 32'(PADDR), 32'(m_paddr));
      chk($sformatf("%s pwrite k%0d", name, k), 32'(PWRITE), 32'(m_pwrite));
      chk($sformatf("%s pwdata k%0d", name, k), PWDATA, m_pwdata);
      if (k == 0) begin
        m_paddr  = addr;
        m_pwrite = we;
        m_pwdata = we ? wdata : 32'h0;
      end
      chk($sformatf("%s psel k%0d", name, k), 32'(PSEL), 32'(k >= 1 && k <= last));
      chk($sformatf("%s penable k%0d", name, k), 32'(PENABLE), 32'(k >= 2 && k <= last));
      chk($sformatf("%s rvalid k%0d", name, k), 32'(rvalid_o), 32'(k == resp));
      exp_err = 1'b0;
      if (k == resp) begin
        m_rdata = to ? 32'h0 : (we ? 32'h0 : prdata);
        exp_err = to ? 1'b1 : slverr;
      end
      chk($sformatf("%s err k%0d", name, k), 32'(err_o), 32'(exp_err));
      chk($sformatf("%s rdata k%0d", name, k), rdata_o, m_rdata);
      @(posedge clk_i); #1;
    end
    req_i = 1'b0; PREADY = 1'b0; PSLVERR = 1'b0;
  endtask

  initial begin
    int gnt_cnt;
    // reset state, with req_i high to confirm nothing is granted
    req_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst gnt", 32'(gnt_o), 32'h0);
    chk("rst psel", 32'(PSEL), 32'h0);
    chk("rst penable", 32'(PENABLE), 32'h0);
    chk("rst rvalid", 32'(rvalid_o), 32'h0);
    chk("rst err", 32'(err_o), 32'h0);
    chk("rst rdata", rdata_o, 32'h0);
    chk("rst paddr", 32'(PADDR), 32'h0);
    chk("rst pwdata", PWDATA, 32'h0);
    chk("rst pwrite", 32'(PWRITE), 32'h0);
    req_i = 1'b0;
    HRESETn = 1'b1;
    @(posedge clk_i); #1;

    xfer("rd_beef", 1'b0, 12'h004, 32'h0, 32'hDEADBEEF, 0, 1'b0);
    xfer("wr_ff_3ws", 1'b1, 12'h100, 32'h0000_00FF, 32'hCAFE_0001, 3, 1'b0);
    xfer("rd_slverr", 1'b0, 12'h020, 32'h0, 32'h5A5A_1234, 1, 1'b1);
    xfer("rd_timeout", 1'b0, 12'h030, 32'h0, 32'h1111_2222, 20, 1'b0);
    xfer("rd_ready_at_lim", 1'b0, 12'h034, 32'h0, 32'h3333_4444, 3, 1'b0);
    xfer("wr_timeout", 1'b1, 12'h038, 32'hAAAA_5555, 32'h0, 4, 1'b1);

    // reset asserted mid-ACCESS
    req_i = 1'b1; we_i = 1'b0; addr_i = 12'h0AB; PREADY = 1'b0;
    @(negedge clk_i);
    chk("arst gnt", 32'(gnt_o), 32'h1);
    @(posedge clk_i); #1;
    req_i = 1'b0;
    @(posedge clk_i); #1;
    @(negedge clk_i);
    chk("arst penable pre", 32'(PENABLE), 32'h1);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst psel", 32'(PSEL), 32'h0);
    chk("arst penable", 32'(PENABLE), 32'h0);
    chk("arst rvalid", 32'(rvalid_o), 32'h0);
    chk("arst paddr", 32'(PADDR), 32'h0);
    m_paddr = '0; m_pwrite = 1'b0; m_pwdata = 32'h0; m_rdata = 32'h0;
    @(posedge clk_i); #1;
    HRESETn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_i);
      chk($sformatf("arst quiet rvalid c%0d", c), 32'(rvalid_o), 32'h0);
      chk($sformatf("arst quiet psel c%0d", c), 32'(PSEL), 32'h0);
      @(posedge clk_i); #1;
    end
    xfer("post_rst_rd", 1'b0, 12'h044, 32'h0, 32'h0BAD_F00D, 0, 1'b0);

    // req_i held high against a zero-wait slave
    gnt_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      req_i = 1'b1; we_i = 1'b0; addr_i = 12'h040;
      PREADY = 1'b1; PRDATA = 32'h1234_5678; PSLVERR = 1'b0;
      @(negedge clk_i);
      if (gnt_o) gnt_cnt++;
      chk($sformatf("stream gnt c%0d", c), 32'(gnt_o), 32'((c % 4) == 0));
      chk($sformatf("stream rvalid c%0d", c), 32'(rvalid_o), 32'((c % 4) == 3));
      @(posedge clk_i); #1;
    end
    req_i = 1'b0; PREADY = 1'b0;
    chk("stream gnt count", 32'(gnt_cnt), 32'd3);
    m_paddr = 12'h040; m_pwrite = 1'b0; m_pwdata = 32'h0; m_rdata = 32'h1234_5678;

    for (int i = 0; i < 40; i++) begin
      xfer($sformatf("rnd%0d", i), 1'($urandom_range(0, 1)), AW'($urandom), $urandom,
           $urandom, int'($urandom_range(0, 6)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
